// File: rtl/hazard_track.sv
`default_nettype none
// ============================================================================
// Module   : hazard_track
// Purpose  : Tracks destination rn / write-enable of in-flight instructions
//            through EX, MEM and WB, feeds the forward unit, detects
//            load-use hazards and drives stall/bubble for IF/ID.
// Options  : HZ_STALL_CNT_EN -> adds stall_cnt[31:0] performance counter
// Revision : 1.0  initial release
// ============================================================================
module hazard_track #(
  parameter int LOAD_STALL = 1   // stall cycles per load-use hazard, 1..3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pause,
  input  logic       flush,
  input  logic       id_valid,
  input  logic [4:0] id_rs_rn,
  input  logic [4:0] id_rt_rn,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  input  logic [4:0] id_wr_rn,
  input  logic       id_we,
  input  logic       id_is_load,
  output logic [4:0] fw_alu_rn,
  output logic       alu_we,
  output logic [4:0] fw_mem_rn,
  output logic       mem_We,
  output logic [4:0] wb_rn,
  output logic       wb_we,
  output logic       stall,
  output logic       bubble
`ifdef HZ_STALL_CNT_EN
  ,
  output logic [31:0] stall_cnt
`endif
);

  localparam logic [0:0] c_IDLE  = 1'b0;
  localparam logic [0:0] c_STALL = 1'b1;

  // The detection cycle is itself the first stall cycle, so the STALL state
  // only covers the remaining LOAD_STALL-1 cycles; r_cnt holds how many of
  // those are still to come after the current one.
  localparam logic       c_SINGLE   = (LOAD_STALL <= 1);
  localparam logic [1:0] c_CNT_INIT = (LOAD_STALL > 1) ? 2'(LOAD_STALL - 2) : 2'd0;

  logic [0:0] r_state;
  logic [1:0] r_cnt;
  logic [4:0] r_ex_rn;
  logic       r_ex_we;
  logic       r_ex_ld;
  logic [4:0] r_mem_rn;
  logic       r_mem_we;
  logic [4:0] r_wb_rn;
  logic       r_wb_we;

  logic       w_alu_we;
  logic       w_rs_hit;
  logic       w_rt_hit;
  logic       w_hz;
  logic       w_stall;
  logic       w_hold_ex;
  logic       w_bubble_ex;
  logic [0:0] w_next_state;
  logic [1:0] w_next_cnt;

  // r0 is never forwarded: a zero rn masks the write enable of every slot
  assign w_alu_we  = r_ex_we  & (r_ex_rn  != 5'd0);
  assign fw_alu_rn = r_ex_rn;
  assign alu_we    = w_alu_we;
  assign fw_mem_rn = r_mem_rn;
  assign mem_We    = r_mem_we & (r_mem_rn != 5'd0);
  assign wb_rn     = r_wb_rn;
  assign wb_we     = r_wb_we  & (r_wb_rn  != 5'd0);

  assign w_rs_hit = id_uses_rs & (id_rs_rn == r_ex_rn);
  assign w_rt_hit = id_uses_rt & (id_rt_rn == r_ex_rn);
  assign w_hz     = r_ex_ld & w_alu_we & id_valid & (w_rs_hit | w_rt_hit);

  // Stall/bubble: whole STALL state, plus the detection cycle unless flushed
  always_comb begin
    w_stall = 1'b0;
    if (r_state == c_STALL) begin
      w_stall = 1'b1;
    end else begin
      w_stall = w_hz & ~flush;
    end
  end

  assign stall  = w_stall;
  assign bubble = w_stall;

  // Next-state logic: decides whether EX is held, bubbled or loaded from ID
  always_comb begin
    w_hold_ex    = 1'b0;
    w_bubble_ex  = flush;
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    if (r_state == c_IDLE) begin
      if (w_hz && !flush) begin
        if (c_SINGLE) begin
          w_bubble_ex = 1'b1;
        end else begin
          w_hold_ex    = 1'b1;
          w_next_state = c_STALL;
          w_next_cnt   = c_CNT_INIT;
        end
      end
    end else begin
      if (flush) begin
        w_next_state = c_IDLE;
        w_next_cnt   = 2'd0;
      end else if (r_cnt != 2'd0) begin
        w_hold_ex  = 1'b1;
        w_next_cnt = r_cnt - 2'd1;
      end else begin
        w_bubble_ex  = 1'b1;
        w_next_state = c_IDLE;
      end
    end
  end

  // Pipeline shift and FSM update; pause freezes everything
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= c_IDLE;
      r_cnt    <= 2'd0;
      r_ex_rn  <= 5'd0;
      r_ex_we  <= 1'b0;
      r_ex_ld  <= 1'b0;
      r_mem_rn <= 5'd0;
      r_mem_we <= 1'b0;
      r_wb_rn  <= 5'd0;
      r_wb_we  <= 1'b0;
    end else if (!pause) begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
      if (w_bubble_ex) begin
        r_ex_rn <= 5'd0;
        r_ex_we <= 1'b0;
        r_ex_ld <= 1'b0;
      end else if (!w_hold_ex) begin
        r_ex_rn <= id_wr_rn;
        r_ex_we <= id_we & id_valid;
        r_ex_ld <= id_is_load;
      end
      // A held load stays in EX, so MEM receives an empty slot behind it
      if (w_hold_ex) begin
        r_mem_rn <= 5'd0;
        r_mem_we <= 1'b0;
      end else begin
        r_mem_rn <= r_ex_rn;
        r_mem_we <= r_ex_we;
      end
      r_wb_rn <= r_mem_rn;
      r_wb_we <= r_mem_we;
    end
  end

`ifdef HZ_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  // Count unpaused stall cycles; wraps naturally at 2^32
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= 32'd0;
    end else if (w_stall && !pause) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_track.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_track
// Purpose  : Directed self-checking bench for hazard_track. Three instances
//            (LOAD_STALL = 1, 2, 3) share one stimulus stream.
//            Checks stall_cnt too when HZ_STALL_CNT_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
module tb_hazard_track;

  logic       clk = 1'b0;
  logic       rst, pause, flush, id_valid, id_uses_rs, id_uses_rt, id_we, id_is_load;
  logic [4:0] id_rs_rn, id_rt_rn, id_wr_rn;

  logic [4:0] o_alu_rn [1:3];
  logic       o_alu_we [1:3];
  logic [4:0] o_mem_rn [1:3];
  logic       o_mem_we [1:3];
  logic [4:0] o_wb_rn  [1:3];
  logic       o_wb_we  [1:3];
  logic       o_stall  [1:3];
  logic       o_bubble [1:3];
`ifdef HZ_STALL_CNT_EN
  logic [31:0] o_scnt  [1:3];
`endif

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;
  int n_st [1:3];
  logic cnt_clr = 1'b1;

  always #5 clk = ~clk;

  for (genvar gi = 1; gi <= 3; gi++) begin : g_dut
    hazard_track #(.LOAD_STALL(gi)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .pause      (pause),
      .flush      (flush),
      .id_valid   (id_valid),
      .id_rs_rn   (id_rs_rn),
      .id_rt_rn   (id_rt_rn),
      .id_uses_rs (id_uses_rs),
      .id_uses_rt (id_uses_rt),
      .id_wr_rn   (id_wr_rn),
      .id_we      (id_we),
      .id_is_load (id_is_load),
      .fw_alu_rn  (o_alu_rn[gi]),
      .alu_we     (o_alu_we[gi]),
      .fw_mem_rn  (o_mem_rn[gi]),
      .mem_We     (o_mem_we[gi]),
      .wb_rn      (o_wb_rn[gi]),
      .wb_we      (o_wb_we[gi]),
      .stall      (o_stall[gi]),
      .bubble     (o_bubble[gi])
`ifdef HZ_STALL_CNT_EN
      ,
      .stall_cnt  (o_scnt[gi])
`endif
    );
  end

  // Independent tally of unpaused stall cycles per instance
  always @(negedge clk) begin
    for (int k = 1; k <= 3; k++) begin
      if (cnt_clr) n_st[k] <= 0;
      else if (o_stall[k] && !pause) n_st[k] <= n_st[k] + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] wr, input logic we, input logic ld,
                        input logic [4:0] rs, input logic urs);
    id_valid   = v;
    id_wr_rn   = wr;
    id_we      = we;
    id_is_load = ld;
    id_rs_rn   = rs;
    id_uses_rs = urs;
    id_rt_rn   = 5'd0;
    id_uses_rt = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; pause = 1'b0; flush = 1'b0; cnt_clr = 1'b1;
    set_id(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    tick();
    rst = 1'b0; cnt_clr = 1'b0;
  endtask

  initial begin
    // T1: reset holds everything at zero even with a valid writer in ID
    rst = 1'b1; pause = 1'b0; flush = 1'b0;
    set_id(1'b1, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0);
    tick(); tick();
    chk("rst_alu_rn", o_alu_rn[1], 0);
    chk("rst_alu_we", o_alu_we[1], 0);
    chk("rst_mem_rn", o_mem_rn[1], 0);
    chk("rst_mem_we", o_mem_we[1], 0);
    chk("rst_wb_rn",  o_wb_rn[1],  0);
    chk("rst_wb_we",  o_wb_we[1],  0);
    chk("rst_stall",  o_stall[1],  0);
    chk("rst_bubble", o_bubble[1], 0);
    rst = 1'b0;
    tick();
    chk("t1_alu_rn", o_alu_rn[1], 5);
    chk("t1_alu_we", o_alu_we[1], 1);

    // T2: three writers shift through EX/MEM/WB
    do_reset();
    set_id(1'b1, 5'd3, 1'b1, 1'b0, 5'd0, 1'b0); tick();
    set_id(1'b1, 5'd4, 1'b1, 1'b0, 5'd0, 1'b0); tick();
    set_id(1'b1, 5'd7, 1'b1, 1'b0, 5'd0, 1'b0); tick();
    chk("t2_alu_rn", o_alu_rn[1], 7);
    chk("t2_mem_rn", o_mem_rn[1], 4);
    chk("t2_wb_rn",  o_wb_rn[1],  3);
    chk("t2_we_all", {o_alu_we[1], o_mem_we[1], o_wb_we[1]}, 3'b111);

    // T3: lw r8 then consumer of r8, single stall cycle
    do_reset();
    set_id(1'b1, 5'd8, 1'b1, 1'b1, 5'd0, 1'b0); tick();
    set_id(1'b1, 5'd9, 1'b1, 1'b0, 5'd8, 1'b1); #1;
    chk("t3_stall",  o_stall[1],  1);
    chk("t3_bubble", o_bubble[1], 1);
    tick();
    chk("t3_stall_end", o_stall[1],  0);
    chk("t3_mem_rn",    o_mem_rn[1], 8);
    chk("t3_mem_we",    o_mem_we[1], 1);
    chk("t3_alu_we",    o_alu_we[1], 0);
    tick();
    chk("t3_consumer_rn", o_alu_rn[1], 9);
    chk("t3_no_restall",  o_stall[1],  0);

    // T4: load to r0 never stalls and never forwards
    do_reset();
    set_id(1'b1, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0); tick();
    chk("t4_alu_we", o_alu_we[1], 0);
    set_id(1'b1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b1); #1;
    chk("t4_stall", o_stall[1], 0);

    // T5a: flush in the hazard cycle wins over the stall
    do_reset();
    set_id(1'b1, 5'd8, 1'b1, 1'b1, 5'd0, 1'b0); tick();
    set_id(1'b1, 5'd9, 1'b1, 1'b0, 5'd8, 1'b1); flush = 1'b1; #1;
    chk("t5_flush_stall", o_stall[1], 0);
    tick();
    flush = 1'b0;
    set_id(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    chk("t5_flush_ex_rn", o_alu_rn[1], 0);
    chk("t5_flush_ex_we", o_alu_we[1], 0);
    chk("t5_flush_mem",   o_mem_rn[1], 8);

    // T5b: pause for 3 cycles in the middle of a 2-cycle stall
    do_reset();
    set_id(1'b1, 5'd8, 1'b1, 1'b1, 5'd0, 1'b0); tick();
    set_id(1'b1, 5'd9, 1'b1, 1'b0, 5'd8, 1'b1); #1;
    chk("t5p_detect", o_stall[2], 1);
    tick();
    pause = 1'b1;
    chk("t5p_stall_in", o_stall[2],  1);
    chk("t5p_ex_held",  o_alu_rn[2], 8);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5p_hold_stall", o_stall[2],  1);
      chk("t5p_hold_ex",    o_alu_rn[2], 8);
      chk("t5p_hold_mem",   o_mem_rn[2], 0);
    end
    pause = 1'b0;
    tick();
    chk("t5p_stall_end", o_stall[2],  0);
    chk("t5p_mem_rn",    o_mem_rn[2], 8);
    chk("t5p_alu_we",    o_alu_we[2], 0);
    tick();
    chk("t5p_consumer", o_alu_rn[2], 9);
    chk("t5p_total",    n_st[2],     2);

    // T6: three load-use pairs; stall totals 1/2/3 per pair per instance
    do_reset();
    for (int p = 0; p < 3; p++) begin
      set_id(1'b1, 5'd8, 1'b1, 1'b1, 5'd0, 1'b0); tick();
      set_id(1'b1, 5'd9, 1'b1, 1'b0, 5'd8, 1'b1);
      tick(); tick(); tick();
      chk("t6_stall_done", o_stall[3], 0);
      tick();
    end
    set_id(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    chk("t6_total_ls1", n_st[1], 3);
    chk("t6_total_ls2", n_st[2], 6);
    chk("t6_total_ls3", n_st[3], 9);
`ifdef HZ_STALL_CNT_EN
    chk("t6_cnt_ls1", o_scnt[1], 3);
    chk("t6_cnt_ls2", o_scnt[2], 6);
    chk("t6_cnt_ls3", o_scnt[3], 9);
    do_reset();
    chk("t6_cnt_rst", o_scnt[3], 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
